// File: rtl/rf_bypass_mp.sv
// rf_bypass_mp: decode-stage register file with two write ports, NUM_RD
// combinational read ports with same-cycle write bypass, a per-register busy
// scoreboard and a registered one-cycle error pulse.
module rf_bypass_mp #(
  parameter int DATA_W   = 16,
  parameter int NUM_REGS = 8,
  parameter int ADDR_W   = 3,
  parameter int NUM_RD   = 2,
  parameter int ZERO_R0  = 0
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [NUM_RD*ADDR_W-1:0] rd_sel,
  input  logic [NUM_RD-1:0]        rd_byp_en,
  output logic [NUM_RD*DATA_W-1:0] rd_data,
  output logic [NUM_RD-1:0]        rd_busy,
  input  logic [1:0]               wr_en,
  input  logic [2*ADDR_W-1:0]      wr_sel,
  input  logic [2*DATA_W-1:0]      wr_data,
  input  logic                     mark_en,
  input  logic [ADDR_W-1:0]        mark_sel,
  output logic                     err
);

  localparam logic [ADDR_W:0] NREGS_C = (ADDR_W+1)'(NUM_REGS);

  function automatic logic in_range(input logic [ADDR_W-1:0] s);
    return {1'b0, s} < NREGS_C;
  endfunction

  function automatic logic is_zero_reg(input logic [ADDR_W-1:0] s);
    return (ZERO_R0 != 0) && (s == '0);
  endfunction

  logic [DATA_W-1:0]   regs_q [NUM_REGS];
  logic [DATA_W-1:0]   regs_d [NUM_REGS];
  logic [NUM_REGS-1:0] busy_q, busy_d;
  logic                err_q, err_d;

  logic [1:0]          wr_vld;
  logic [ADDR_W-1:0]   ws [2];
  logic [DATA_W-1:0]   wd [2];
  logic                wr_err, rd_err, mark_err;

  // Write-port decode: a write is valid only out of reset, in range and not
  // aimed at a hard-wired zero register.
  always_comb begin
    wr_err = 1'b0;
    for (int unsigned k = 0; k < 2; k++) begin
      ws[k]     = wr_sel[k*ADDR_W +: ADDR_W];
      wd[k]     = wr_data[k*DATA_W +: DATA_W];
      wr_vld[k] = rst && wr_en[k] && in_range(ws[k]) && !is_zero_reg(ws[k]);
      if (rst && wr_en[k] && !in_range(ws[k])) wr_err = 1'b1;
    end
    if (wr_vld[0] && wr_vld[1] && (ws[0] == ws[1])) wr_err = 1'b1;
    mark_err = rst && mark_en && !in_range(mark_sel);
  end

  // Next array/scoreboard state: port 1 applied after port 0 so it wins a
  // collision; the mark is applied last so it wins over a clearing write.
  always_comb begin
    regs_d = regs_q;
    busy_d = busy_q;
    for (int unsigned r = 0; r < NUM_REGS; r++) begin
      for (int unsigned k = 0; k < 2; k++) begin
        if (wr_vld[k] && (ws[k] == ADDR_W'(r))) begin
          regs_d[r] = wd[k];
          busy_d[r] = 1'b0;
        end
      end
      if (rst && mark_en && (mark_sel == ADDR_W'(r)) && !is_zero_reg(mark_sel))
        busy_d[r] = 1'b1;
    end
  end

  // Read ports: array lookup, then bypass (port 1 last, so it has priority),
  // then the out-of-range and zero-register overrides.
  always_comb begin : rd_mux
    logic [ADDR_W-1:0] rs;
    logic [DATA_W-1:0] rv;
    logic              rb;
    rd_data = '0;
    rd_busy = '0;
    rd_err  = 1'b0;
    for (int unsigned i = 0; i < NUM_RD; i++) begin
      rs = rd_sel[i*ADDR_W +: ADDR_W];
      rv = '0;
      rb = 1'b0;
      for (int unsigned r = 0; r < NUM_REGS; r++) begin
        if (rs == ADDR_W'(r)) begin
          rv = regs_q[r];
          rb = busy_q[r];
        end
      end
      for (int unsigned k = 0; k < 2; k++) begin
        if (rd_byp_en[i] && wr_vld[k] && (ws[k] == rs)) begin
          rv = wd[k];
          rb = 1'b0;
        end
      end
      if (!in_range(rs)) begin
        rv = '0;
        rb = 1'b0;
        if (rst) rd_err = 1'b1;
      end
      if (is_zero_reg(rs)) begin
        rv = '0;
        rb = 1'b0;
      end
      rd_data[i*DATA_W +: DATA_W] = rv;
      rd_busy[i]                  = rb;
    end
  end

  // Any error flagged this cycle becomes a one-cycle pulse next cycle.
  always_comb begin
    err_d = wr_err | rd_err | mark_err;
  end

  // State registers with asynchronous active-low clear.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int unsigned r = 0; r < NUM_REGS; r++) regs_q[r] <= '0;
      busy_q <= '0;
      err_q  <= 1'b0;
    end else begin
      regs_q <= regs_d;
      busy_q <= busy_d;
      err_q  <= err_d;
    end
  end

  assign err = err_q;

endmodule

// File: tb/tb_rf_bypass_mp.sv
// Directed bench for rf_bypass_mp: default 8x16 instance, a ZERO_R0=1
// instance and a 6-register / 3-read-port instance share clock and reset.
module tb_rf_bypass_mp;

  int compared   = 0;
  int mismatched = 0;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  // default instance
  logic [5:0]  rd_sel_a;   logic [1:0] byp_a;  logic [31:0] rd_data_a; logic [1:0] busy_a;
  logic [1:0]  wr_en_a;    logic [5:0] wsel_a; logic [31:0] wdat_a;
  logic        mark_en_a;  logic [2:0] msel_a; logic        err_a;
  // ZERO_R0 instance
  logic [5:0]  rd_sel_z;   logic [1:0] byp_z;  logic [31:0] rd_data_z; logic [1:0] busy_z;
  logic [1:0]  wr_en_z;    logic [5:0] wsel_z; logic [31:0] wdat_z;
  logic        mark_en_z;  logic [2:0] msel_z; logic        err_z;
  // 6 registers, 3 read ports
  logic [8:0]  rd_sel_n;   logic [2:0] byp_n;  logic [47:0] rd_data_n; logic [2:0] busy_n;
  logic [1:0]  wr_en_n;    logic [5:0] wsel_n; logic [31:0] wdat_n;
  logic        mark_en_n;  logic [2:0] msel_n; logic        err_n;

  rf_bypass_mp u_a (
    .clk(clk), .rst(rst), .rd_sel(rd_sel_a), .rd_byp_en(byp_a), .rd_data(rd_data_a),
    .rd_busy(busy_a), .wr_en(wr_en_a), .wr_sel(wsel_a), .wr_data(wdat_a),
    .mark_en(mark_en_a), .mark_sel(msel_a), .err(err_a));

  rf_bypass_mp #(.ZERO_R0(1)) u_z (
    .clk(clk), .rst(rst), .rd_sel(rd_sel_z), .rd_byp_en(byp_z), .rd_data(rd_data_z),
    .rd_busy(busy_z), .wr_en(wr_en_z), .wr_sel(wsel_z), .wr_data(wdat_z),
    .mark_en(mark_en_z), .mark_sel(msel_z), .err(err_z));

  rf_bypass_mp #(.NUM_REGS(6), .NUM_RD(3)) u_n (
    .clk(clk), .rst(rst), .rd_sel(rd_sel_n), .rd_byp_en(byp_n), .rd_data(rd_data_n),
    .rd_busy(busy_n), .wr_en(wr_en_n), .wr_sel(wsel_n), .wr_data(wdat_n),
    .mark_en(mark_en_n), .mark_sel(msel_n), .err(err_n));

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic idle_all();
    wr_en_a = '0; mark_en_a = 1'b0; byp_a = '0;
    wr_en_z = '0; mark_en_z = 1'b0; byp_z = '0;
    wr_en_n = '0; mark_en_n = 1'b0; byp_n = '0;
  endtask

  // Inputs change just after the falling edge; checks run 1 time unit later.
  task automatic next_cycle();
    @(negedge clk);
    idle_all();
  endtask

  initial begin
    rst = 1'b0;
    rd_sel_a = '0; wsel_a = '0; wdat_a = '0; msel_a = '0;
    rd_sel_z = '0; wsel_z = '0; wdat_z = '0; msel_z = '0;
    rd_sel_n = '0; wsel_n = '0; wdat_n = '0; msel_n = '0;
    idle_all();

    // 1. Reset: writes, marks and bypass are all suppressed.
    wr_en_a = 2'b11; wsel_a = {3'd3, 3'd5}; wdat_a = {16'hAAAA, 16'h5555};
    mark_en_a = 1'b1; msel_a = 3'd5; rd_sel_a = {3'd3, 3'd5}; byp_a = 2'b11;
    @(negedge clk); @(negedge clk); #1;
    chk("rst_rd_data", rd_data_a, 64'h0);
    chk("rst_rd_busy", busy_a, 64'h0);
    chk("rst_err", err_a, 64'h0);
    @(negedge clk);
    rst = 1'b1; idle_all(); rd_sel_a = {3'd5, 3'd3};
    @(negedge clk); #1;
    chk("post_rst_r3_r5", rd_data_a, 64'h0);
    chk("post_rst_busy", busy_a, 64'h0);
    chk("post_rst_err", err_a, 64'h0);

    // 2. Bypass on port 0, then a non-bypassed write to register 6.
    next_cycle();
    wr_en_a = 2'b01; wsel_a = {3'd0, 3'd5}; wdat_a = {16'h0, 16'hBEEF};
    rd_sel_a = {3'd0, 3'd5}; byp_a = 2'b01; #1;
    chk("byp_same_cycle", rd_data_a, 64'h0000_BEEF);
    next_cycle(); #1;
    chk("byp_array_r5", rd_data_a, 64'h0000_BEEF);
    next_cycle();
    wr_en_a = 2'b01; wsel_a = {3'd0, 3'd6}; wdat_a = {16'h0, 16'hBEEF};
    rd_sel_a = {3'd0, 3'd6}; #1;
    chk("nobyp_old", rd_data_a, 64'h0000_0000);
    next_cycle(); #1;
    chk("nobyp_next", rd_data_a, 64'h0000_BEEF);
    chk("nobyp_err", err_a, 64'h0);

    // 3. Both ports write register 2: port 1 wins and err pulses once.
    next_cycle();
    wr_en_a = 2'b11; wsel_a = {3'd2, 3'd2}; wdat_a = {16'h2222, 16'h1111};
    rd_sel_a = {3'd5, 3'd2}; byp_a = 2'b01; #1;
    chk("coll_byp", rd_data_a, 64'hBEEF_2222);
    chk("coll_err_before", err_a, 64'h0);
    next_cycle(); #1;
    chk("coll_array", rd_data_a, 64'hBEEF_2222);
    chk("coll_err_pulse", err_a, 64'h1);
    next_cycle(); #1;
    chk("coll_err_clear", err_a, 64'h0);

    // 4. Scoreboard on register 4 via read port 1.
    next_cycle();
    mark_en_a = 1'b1; msel_a = 3'd4; rd_sel_a = {3'd4, 3'd2}; #1;
    chk("sb_mark_same", busy_a, 64'h0);
    next_cycle(); #1;
    chk("sb_mark_next", busy_a, 64'h2);
    byp_a = 2'b10; #1;
    chk("sb_byp_no_write", busy_a, 64'h2);
    next_cycle();
    wr_en_a = 2'b01; wsel_a = {3'd0, 3'd4}; wdat_a = {16'h0, 16'h4444}; byp_a = 2'b10; #1;
    chk("sb_byp_busy", busy_a, 64'h0);
    chk("sb_byp_data", rd_data_a, 64'h4444_2222);
    next_cycle(); #1;
    chk("sb_cleared", busy_a, 64'h0);
    chk("sb_data", rd_data_a, 64'h4444_2222);
    next_cycle();
    mark_en_a = 1'b1; msel_a = 3'd4;
    wr_en_a = 2'b10; wsel_a = {3'd4, 3'd0}; wdat_a = {16'h5555, 16'h0}; #1;
    chk("sb_mark_wr_same", busy_a, 64'h0);
    next_cycle(); #1;
    chk("sb_mark_wins", busy_a, 64'h2);
    chk("sb_mark_wr_data", rd_data_a, 64'h5555_2222);

    // 5. ZERO_R0: register 0 reads 0, writes to it drop silently.
    next_cycle();
    wr_en_z = 2'b11; wsel_z = {3'd1, 3'd0}; wdat_z = {16'h00AB, 16'hFFFF};
    rd_sel_z = {3'd0, 3'd0}; byp_z = 2'b01; #1;
    chk("z_r0_rd", rd_data_z, 64'h0);
    rd_sel_z = {3'd1, 3'd0}; byp_z = 2'b11; #1;
    chk("z_r1_byp", rd_data_z, 64'h00AB_0000);
    next_cycle(); rd_sel_z = {3'd1, 3'd0}; #1;
    chk("z_r0_array", rd_data_z, 64'h00AB_0000);
    chk("z_err", err_z, 64'h0);
    mark_en_z = 1'b1; msel_z = 3'd0;
    next_cycle(); rd_sel_z = {3'd1, 3'd0}; #1;
    chk("z_r0_busy", busy_z, 64'h0);

    // 6. Six registers, three read ports: out-of-range handling.
    next_cycle();
    wr_en_n = 2'b11; wsel_n = {3'd0, 3'd5}; wdat_n = {16'h0011, 16'h0055};
    next_cycle(); rd_sel_n = {3'd7, 3'd0, 3'd5}; #1;
    chk("n_rd_oor_data", rd_data_n, 64'h0000_0011_0055);
    chk("n_rd_oor_busy", busy_n, 64'h0);
    next_cycle(); rd_sel_n = {3'd1, 3'd0, 3'd5}; #1;
    chk("n_rd_oor_err", err_n, 64'h1);
    next_cycle(); #1;
    chk("n_err_clear", err_n, 64'h0);
    next_cycle();
    wr_en_n = 2'b01; wsel_n = {3'd0, 3'd6}; wdat_n = {16'h0, 16'hFFFF}; byp_n = 3'b111; #1;
    chk("n_wr_oor_byp", rd_data_n, 64'h0000_0011_0055);
    next_cycle(); #1;
    chk("n_wr_oor_err", err_n, 64'h1);
    chk("n_wr_oor_array", rd_data_n, 64'h0000_0011_0055);
    rd_sel_n = {3'd4, 3'd3, 3'd2}; #1;
    chk("n_wr_oor_array2", rd_data_n, 64'h0);
    mark_en_n = 1'b1; msel_n = 3'd7;
    next_cycle(); #1;
    chk("n_mark_oor_err", err_n, 64'h1);
    chk("n_mark_oor_busy", busy_n, 64'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
